// File: rtl/ace_snoop_responder_if.sv
// Bundles the ACE snoop channels (AC/CR/CD) with the tag lookup and state
// update side channels of the responder.
interface ace_snoop_responder_if #(
  parameter int AddrWidth    = 64,
  parameter int DataWidth    = 64,
  parameter int BeatsPerLine = 4
);
  logic                              ac_valid_i;
  logic                              ac_ready_o;
  logic [AddrWidth-1:0]              ac_addr_i;
  logic [3:0]                        ac_snoop_i;
  logic [2:0]                        ac_prot_i;

  logic                              cr_valid_o;
  logic                              cr_ready_i;
  logic [4:0]                        cr_resp_o;

  logic                              cd_valid_o;
  logic                              cd_ready_i;
  logic [DataWidth-1:0]              cd_data_o;
  logic                              cd_last_o;

  logic                              lkp_req_o;
  logic [AddrWidth-1:0]              lkp_addr_o;
  logic                              lkp_gnt_i;
  logic                              lkp_hit_i;
  logic                              lkp_dirty_i;
  logic                              lkp_unique_i;
  logic [DataWidth*BeatsPerLine-1:0] lkp_line_i;

  logic                              upd_valid_o;
  logic                              upd_ready_i;
  logic [1:0]                        upd_op_o;
  logic [AddrWidth-1:0]              upd_addr_o;

  modport slave (
    input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i,
    output ac_ready_o,
    output cr_valid_o, cr_resp_o,
    input  cr_ready_i,
    output cd_valid_o, cd_data_o, cd_last_o,
    input  cd_ready_i,
    output lkp_req_o, lkp_addr_o,
    input  lkp_gnt_i, lkp_hit_i, lkp_dirty_i, lkp_unique_i, lkp_line_i,
    output upd_valid_o, upd_op_o, upd_addr_o,
    input  upd_ready_i
  );

  modport master (
    output ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i,
    input  ac_ready_o,
    input  cr_valid_o, cr_resp_o,
    output cr_ready_i,
    input  cd_valid_o, cd_data_o, cd_last_o,
    output cd_ready_i,
    input  lkp_req_o, lkp_addr_o,
    output lkp_gnt_i, lkp_hit_i, lkp_dirty_i, lkp_unique_i, lkp_line_i,
    input  upd_valid_o, upd_op_o, upd_addr_o,
    output upd_ready_i
  );
endinterface

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one snoop at a time, looks up the tag, applies the
// cache state change, then returns the snoop response and optionally the line.
module ace_snoop_responder #(
  parameter int AddrWidth    = 64,
  parameter int DataWidth    = 64,
  parameter int BeatsPerLine = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ace_snoop_responder_if.slave bus
);

  localparam int BeatW = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BeatsPerLine - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_UPDATE  = 3'd2,
    ST_SEND_CR = 3'd3,
    ST_SEND_CD = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [AddrWidth-1:0] addr_r;
  logic [3:0]           snoop_r;
  logic [2:0]           prot_r;
  logic                 hit_r;
  logic                 dirty_r;
  logic                 unique_r;
  logic [DataWidth-1:0] beats_r [BeatsPerLine];
  logic [BeatW-1:0]     beat_r;
  logic [1:0]           gnt_op_s;
  logic [1:0]           cur_op_s;
  logic [4:0]           cur_resp_s;
  logic                 prot_unused_s;

  // Cache state change: 01 keeps a SharedClean copy, 10 invalidates; misses never touch the cache.
  function automatic logic [1:0] snoop_op(input logic [3:0] snoop, input logic hit);
    logic [1:0] op;
    case (snoop)
      4'b0001:                   op = 2'b01;
      4'b0111, 4'b1001, 4'b1101: op = 2'b10;
      default:                   op = 2'b00;
    endcase
    if (hit) snoop_op = op;
    else     snoop_op = 2'b00;
  endfunction

  // Response bits {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  function automatic logic [4:0] snoop_resp(input logic [3:0] snoop, input logic hit,
                                            input logic dirty, input logic uniq);
    logic dt, sh, pd, ok;
    dt = 1'b0; sh = 1'b0; pd = 1'b0; ok = 1'b1;
    case (snoop)
      4'b0000: begin dt = 1'b1;  sh = 1'b1;              end
      4'b0001: begin dt = 1'b1;  sh = 1'b1; pd = dirty;  end
      4'b0111: begin dt = 1'b1;             pd = dirty;  end
      4'b1001: begin dt = dirty;            pd = dirty;  end
      4'b1101: begin dt = 1'b0;                          end
      default: ok = 1'b0;
    endcase
    if (hit && ok) snoop_resp = {uniq, sh, pd, 1'b0, dt};
    else           snoop_resp = 5'b00000;
  endfunction

  assign gnt_op_s      = snoop_op(snoop_r, bus.lkp_hit_i);
  assign cur_op_s      = snoop_op(snoop_r, hit_r);
  assign cur_resp_s    = snoop_resp(snoop_r, hit_r, dirty_r, unique_r);
  assign prot_unused_s = ^prot_r;

  // State register, request/lookup holding registers and CD beat counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      addr_r   <= '0;
      snoop_r  <= 4'b0000;
      prot_r   <= 3'b000;
      hit_r    <= 1'b0;
      dirty_r  <= 1'b0;
      unique_r <= 1'b0;
      beat_r   <= '0;
      for (int k = 0; k < BeatsPerLine; k++) beats_r[k] <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE && bus.ac_valid_i) begin
        addr_r  <= bus.ac_addr_i;
        snoop_r <= bus.ac_snoop_i;
        prot_r  <= bus.ac_prot_i;
      end
      // The line is captured at grant so a later invalidate cannot change returned data.
      if (state_r == ST_LOOKUP && bus.lkp_gnt_i) begin
        hit_r    <= bus.lkp_hit_i;
        dirty_r  <= bus.lkp_dirty_i;
        unique_r <= bus.lkp_unique_i;
        for (int k = 0; k < BeatsPerLine; k++)
          beats_r[k] <= bus.lkp_line_i[k*DataWidth +: DataWidth];
      end
      if (state_r == ST_SEND_CR && bus.cr_ready_i) begin
        beat_r <= '0;
      end else if (state_r == ST_SEND_CD && bus.cd_ready_i && beat_r != LastBeat) begin
        beat_r <= beat_r + BeatW'(1);
      end
    end
  end

  // Next-state and output decode; every payload reads zero while its valid is low.
  always_comb begin
    state_s         = state_r;
    bus.ac_ready_o  = 1'b0;
    bus.lkp_req_o   = 1'b0;
    bus.lkp_addr_o  = '0;
    bus.upd_valid_o = 1'b0;
    bus.upd_op_o    = 2'b00;
    bus.upd_addr_o  = '0;
    bus.cr_valid_o  = 1'b0;
    bus.cr_resp_o   = 5'b00000;
    bus.cd_valid_o  = 1'b0;
    bus.cd_data_o   = '0;
    bus.cd_last_o   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bus.ac_ready_o = 1'b1;
        if (bus.ac_valid_i) state_s = ST_LOOKUP;
        else                state_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        bus.lkp_req_o  = 1'b1;
        bus.lkp_addr_o = addr_r;
        if (bus.lkp_gnt_i) begin
          if (gnt_op_s != 2'b00) state_s = ST_UPDATE;
          else                   state_s = ST_SEND_CR;
        end else begin
          state_s = ST_LOOKUP;
        end
      end
      ST_UPDATE: begin
        bus.upd_valid_o = 1'b1;
        bus.upd_op_o    = cur_op_s;
        bus.upd_addr_o  = addr_r;
        if (bus.upd_ready_i) state_s = ST_SEND_CR;
        else                 state_s = ST_UPDATE;
      end
      ST_SEND_CR: begin
        bus.cr_valid_o = 1'b1;
        bus.cr_resp_o  = cur_resp_s;
        if (bus.cr_ready_i) begin
          if (cur_resp_s[0]) state_s = ST_SEND_CD;
          else               state_s = ST_IDLE;
        end else begin
          state_s = ST_SEND_CR;
        end
      end
      ST_SEND_CD: begin
        bus.cd_valid_o = 1'b1;
        bus.cd_data_o  = beats_r[beat_r];
        bus.cd_last_o  = (beat_r == LastBeat);
        if (bus.cd_ready_i && beat_r == LastBeat) state_s = ST_IDLE;
        else                                      state_s = ST_SEND_CD;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench: directed and random snoops scored against a rule-level
// model of the ACE snoop response, state update and data return.
module tb_ace_snoop_responder;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int BPL = 4;
  localparam int LW  = DW * BPL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ace_snoop_responder_if #(.AddrWidth(AW), .DataWidth(DW), .BeatsPerLine(BPL)) bus ();

  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .BeatsPerLine(BPL)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] resp;
  } exp_t;

  // Expected outcome straight from the snoop rules.
  function automatic exp_t model(input logic [3:0] code, input logic hit, input logic dirty,
                                 input logic uniq);
    exp_t e;
    bit known, xfer, shared, passd;
    e = '0;
    known = (code == 4'd0) || (code == 4'd1) || (code == 4'd7) || (code == 4'd9) || (code == 4'd13);
    if (!hit || !known) return e;
    xfer   = (code == 4'd0 || code == 4'd1 || code == 4'd7) ? 1'b1 : ((code == 4'd9) ? dirty : 1'b0);
    shared = (code == 4'd0 || code == 4'd1);
    passd  = (code == 4'd0 || code == 4'd13) ? 1'b0 : dirty;
    e.op   = (code == 4'd0) ? 2'b00 : ((code == 4'd1) ? 2'b01 : 2'b10);
    e.resp = {uniq, shared, passd, 1'b0, xfer};
    return e;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < BPL; k++) l[k*DW +: DW] = {$urandom, $urandom};
    return l;
  endfunction

  function automatic logic rnd_ready(input int stall_pct);
    return (int'($urandom_range(0, 99)) >= stall_pct) ? 1'b1 : 1'b0;
  endfunction

  // Runs one snoop end to end, scoring every cycle. abort_beat>=0 pulls reset while that beat is on CD.
  task automatic do_snoop(input logic [3:0] code, input logic hit, input logic dirty, input logic uniq,
                          input logic [LW-1:0] line, input int stall_pct, input int gnt_delay,
                          input int cr_hold, input bit pend, input int abort_beat,
                          output int lat_lkp, output int lat_cr);
    exp_t e;
    logic [AW-1:0] addr;
    int cyc, beats, exp_beats;
    bit fin, upd_done, cr_done, ps_upd, ps_cr, ps_cd;
    e = model(code, hit, dirty, uniq);
    exp_beats = e.resp[0] ? BPL : 0;
    addr = {$urandom, $urandom};
    lat_lkp = -1; lat_cr = -1; cyc = 0;

    @(negedge clk);
    bus.ac_addr_i = addr; bus.ac_snoop_i = code; bus.ac_prot_i = 3'($urandom); bus.ac_valid_i = 1'b1;
    total++;
    if (bus.ac_ready_o !== 1'b1) begin
      bad++; $display("FAIL ac_ready_idle: got %b want 1", bus.ac_ready_o);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); cyc++;
      if (pend) begin
        if (c == 0) begin bus.ac_addr_i = {$urandom, $urandom}; bus.ac_snoop_i = 4'd1; end
      end else begin
        bus.ac_valid_i = 1'b0;
      end
      if (bus.lkp_req_o === 1'b1) break;
    end
    total++;
    if (bus.lkp_req_o !== 1'b1 || bus.lkp_addr_o !== addr) begin
      bad++; $display("FAIL lkp_req: got req=%b addr=%h want req=1 addr=%h", bus.lkp_req_o, bus.lkp_addr_o, addr);
    end
    lat_lkp = cyc;
    for (int d = 0; d < gnt_delay; d++) begin
      @(negedge clk); cyc++;
      total++;
      if (bus.lkp_req_o !== 1'b1 || bus.lkp_addr_o !== addr || bus.ac_ready_o !== 1'b0) begin
        bad++; $display("FAIL lkp_hold: got req=%b ac_ready=%b want req=1 ac_ready=0", bus.lkp_req_o, bus.ac_ready_o);
      end
    end
    bus.lkp_gnt_i = 1'b1; bus.lkp_hit_i = hit; bus.lkp_dirty_i = dirty; bus.lkp_unique_i = uniq;
    bus.lkp_line_i = line;

    upd_done = (e.op == 2'b00); cr_done = 1'b0; beats = 0; fin = 1'b0;
    ps_upd = 1'b0; ps_cr = 1'b0; ps_cd = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk); cyc++;
      bus.lkp_gnt_i = 1'b0; bus.lkp_hit_i = 1'($urandom); bus.lkp_dirty_i = 1'($urandom);
      bus.lkp_unique_i = 1'($urandom); bus.lkp_line_i = rand_line();
      if (bus.cr_valid_o === 1'b1 && lat_cr < 0) lat_cr = cyc;
      if (abort_beat >= 0 && bus.cd_valid_o === 1'b1 && beats == abort_beat) begin
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus.cd_valid_o !== 1'b0 || bus.ac_ready_o !== 1'b1 || bus.cr_valid_o !== 1'b0 ||
            bus.upd_valid_o !== 1'b0 || bus.lkp_req_o !== 1'b0 || bus.cd_data_o !== '0) begin
          bad++; $display("FAIL mid_reset: got cd_valid=%b ac_ready=%b cr_valid=%b want 0 1 0",
                          bus.cd_valid_o, bus.ac_ready_o, bus.cr_valid_o);
        end
        rst_n = 1'b1; bus.ac_valid_i = 1'b0;
        return;
      end
      total++;
      if (bus.ac_ready_o !== 1'b0 || bus.lkp_req_o !== 1'b0) begin
        bad++; $display("FAIL busy: got ac_ready=%b lkp_req=%b want 0 0", bus.ac_ready_o, bus.lkp_req_o);
      end
      total++;
      if (bus.upd_valid_o === 1'b1) begin
        if (upd_done || bus.upd_op_o !== e.op || bus.upd_addr_o !== addr) begin
          bad++; $display("FAIL upd: got op=%b addr=%h want op=%b addr=%h expected=%b",
                          bus.upd_op_o, bus.upd_addr_o, e.op, addr, !upd_done);
        end
      end else if (ps_upd || bus.upd_op_o !== 2'b00 || bus.upd_addr_o !== '0) begin
        bad++; $display("FAIL upd_idle: got op=%b retracted=%b want op=00 held", bus.upd_op_o, ps_upd);
      end
      total++;
      if (bus.cr_valid_o === 1'b1) begin
        if (!upd_done || cr_done || bus.cr_resp_o !== e.resp) begin
          bad++; $display("FAIL cr_resp: got %b want %b (upd_done=%b)", bus.cr_resp_o, e.resp, upd_done);
        end
      end else if (ps_cr || bus.cr_resp_o !== 5'b00000) begin
        bad++; $display("FAIL cr_idle: got resp=%b retracted=%b want 00000 held", bus.cr_resp_o, ps_cr);
      end
      total++;
      if (bus.cd_valid_o === 1'b1) begin
        if (!cr_done || beats >= exp_beats || bus.cd_data_o !== line[beats*DW +: DW] ||
            bus.cd_last_o !== (beats == exp_beats - 1)) begin
          bad++; $display("FAIL cd_beat%0d: got data=%h last=%b want data=%h last=%b",
                          beats, bus.cd_data_o, bus.cd_last_o, line[beats*DW +: DW], beats == exp_beats - 1);
        end
      end else if (ps_cd || bus.cd_data_o !== '0 || bus.cd_last_o !== 1'b0) begin
        bad++; $display("FAIL cd_idle: got data=%h last=%b retracted=%b want 0", bus.cd_data_o, bus.cd_last_o, ps_cd);
      end
      bus.upd_ready_i = rnd_ready(stall_pct);
      if (bus.cr_valid_o === 1'b1 && cr_hold > 0) begin
        bus.cr_ready_i = 1'b0; cr_hold--;
      end else begin
        bus.cr_ready_i = rnd_ready(stall_pct);
      end
      bus.cd_ready_i = rnd_ready(stall_pct);
      ps_upd = (bus.upd_valid_o === 1'b1) && !bus.upd_ready_i;
      ps_cr  = (bus.cr_valid_o === 1'b1) && !bus.cr_ready_i;
      ps_cd  = (bus.cd_valid_o === 1'b1) && !bus.cd_ready_i;
      if (bus.upd_valid_o === 1'b1 && bus.upd_ready_i) upd_done = 1'b1;
      if (bus.cr_valid_o === 1'b1 && bus.cr_ready_i) cr_done = 1'b1;
      if (bus.cd_valid_o === 1'b1 && bus.cd_ready_i) beats++;
      fin = cr_done && (beats == exp_beats);
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL timeout: got cr_done=%b beats=%0d want 1 %0d", cr_done, beats, exp_beats);
    end
    @(negedge clk);
    total++;
    if (bus.ac_ready_o !== 1'b1 || bus.upd_valid_o !== 1'b0 || bus.cr_valid_o !== 1'b0 || bus.cd_valid_o !== 1'b0) begin
      bad++; $display("FAIL back_idle: got ac_ready=%b upd=%b cr=%b cd=%b want 1 0 0 0",
                      bus.ac_ready_o, bus.upd_valid_o, bus.cr_valid_o, bus.cd_valid_o);
    end
    bus.ac_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ac_valid_i = 1'b1; bus.ac_snoop_i = 4'd1; bus.lkp_gnt_i = 1'b1; bus.lkp_hit_i = 1'b1;
    bus.cr_ready_i = 1'b1; bus.cd_ready_i = 1'b1; bus.upd_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.ac_ready_o !== 1'b1 || bus.lkp_req_o !== 1'b0 || bus.lkp_addr_o !== '0 || bus.upd_valid_o !== 1'b0 ||
        bus.upd_op_o !== 2'b00 || bus.upd_addr_o !== '0 || bus.cr_valid_o !== 1'b0 || bus.cr_resp_o !== 5'b00000 ||
        bus.cd_valid_o !== 1'b0 || bus.cd_data_o !== '0 || bus.cd_last_o !== 1'b0) begin
      bad++; $display("FAIL reset_state: got ac_ready=%b lkp=%b upd=%b cr=%b cd=%b want 1 0 0 0 0",
                      bus.ac_ready_o, bus.lkp_req_o, bus.upd_valid_o, bus.cr_valid_o, bus.cd_valid_o);
    end
    bus.ac_valid_i = 1'b0; bus.lkp_gnt_i = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.ac_ready_o !== 1'b1 || bus.lkp_req_o !== 1'b0) begin
      bad++; $display("FAIL reset_release: got ac_ready=%b lkp_req=%b want 1 0", bus.ac_ready_o, bus.lkp_req_o);
    end
  endtask

  task automatic test_read_shared();
    logic [LW-1:0] l;
    int a, b;
    l = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    do_snoop(4'b0001, 1'b1, 1'b1, 1'b0, l, 0, 1, 0, 1'b0, -1, a, b);
  endtask

  task automatic test_read_unique_stall();
    int a, b;
    do_snoop(4'b0111, 1'b1, 1'b0, 1'b1, rand_line(), 50, 2, 0, 1'b0, -1, a, b);
  endtask

  task automatic test_invalidates();
    int a, b;
    do_snoop(4'b1001, 1'b1, 1'b0, 1'($urandom), rand_line(), 20, 0, 0, 1'b0, -1, a, b);
    do_snoop(4'b1001, 1'b1, 1'b1, 1'b0, rand_line(), 20, 0, 0, 1'b0, -1, a, b);
    do_snoop(4'b1101, 1'b1, 1'b1, 1'b1, rand_line(), 20, 1, 0, 1'b0, -1, a, b);
  endtask

  task automatic test_miss_unsupported();
    int a, b;
    do_snoop(4'b0000, 1'b0, 1'b1, 1'b1, rand_line(), 10, 0, 0, 1'b0, -1, a, b);
    do_snoop(4'b0010, 1'b1, 1'b1, 1'b1, rand_line(), 10, 0, 0, 1'b0, -1, a, b);
  endtask

  task automatic test_latency();
    int lk, lc;
    do_snoop(4'b0000, 1'b1, 1'b0, 1'b0, rand_line(), 0, 0, 0, 1'b0, -1, lk, lc);
    total++;
    if (lk != 1 || lc != 2) begin
      bad++; $display("FAIL latency_op00: got lkp=%0d cr=%0d want 1 2", lk, lc);
    end
    do_snoop(4'b0001, 1'b1, 1'b0, 1'b0, rand_line(), 0, 0, 0, 1'b0, -1, lk, lc);
    total++;
    if (lk != 1 || lc != 3) begin
      bad++; $display("FAIL latency_op01: got lkp=%0d cr=%0d want 1 3", lk, lc);
    end
  endtask

  task automatic test_back_to_back();
    int a, b;
    do_snoop(4'b0001, 1'b1, 1'b0, 1'b0, rand_line(), 0, 0, 5, 1'b1, -1, a, b);
    do_snoop(4'b0111, 1'b1, 1'b1, 1'b0, rand_line(), 0, 0, 0, 1'b0, -1, a, b);
  endtask

  task automatic test_reset_mid();
    int a, b;
    do_snoop(4'b0001, 1'b1, 1'b1, 1'b0, rand_line(), 0, 0, 0, 1'b0, 2, a, b);
    do_snoop(4'b0001, 1'b1, 1'b0, 1'b1, rand_line(), 20, 1, 0, 1'b0, -1, a, b);
  endtask

  task automatic test_random();
    logic [3:0] codes [6];
    logic [3:0] code;
    int a, b;
    codes[0] = 4'd0; codes[1] = 4'd1; codes[2] = 4'd7; codes[3] = 4'd9; codes[4] = 4'd13; codes[5] = 4'd2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) code = 4'($urandom);
      else code = codes[$urandom_range(0, 5)];
      do_snoop(code, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), rand_line(),
               int'($urandom_range(0, 60)), int'($urandom_range(0, 3)), 0, 1'b0, -1, a, b);
    end
  endtask

  initial begin
    bus.ac_valid_i = 1'b0; bus.ac_addr_i = '0; bus.ac_snoop_i = 4'd0; bus.ac_prot_i = 3'd0;
    bus.cr_ready_i = 1'b0; bus.cd_ready_i = 1'b0; bus.upd_ready_i = 1'b0;
    bus.lkp_gnt_i = 1'b0; bus.lkp_hit_i = 1'b0; bus.lkp_dirty_i = 1'b0; bus.lkp_unique_i = 1'b0;
    bus.lkp_line_i = '0;
    test_reset();
    test_read_shared();
    test_read_unique_stall();
    test_invalidates();
    test_miss_unsupported();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
